data_req_ctrl: RTL and testbench

DATA_REQ_CTRL -- requirements
Module: data_req_ctrl

---
 rtl/data_req_ctrl.sv | 133 +++++++++++++
 tb/tb_data_req_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_req_ctrl.sv
// Data-side request controller: turns single ops into SRAM-like req/addr_ok/data_ok
// transactions, tracks outstanding requests in order and drops flushed responses.
module data_req_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        op_valid,
    input  logic        op_wr,
    input  logic [1:0]  op_size,
    input  logic [31:0] op_addr,
    input  logic [3:0]  op_wstrb,
    input  logic [31:0] op_wdata,
    output logic        op_ready,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [31:0] data_sram_addr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        rsp_valid,
    output logic        rsp_wr,
    output logic [31:0] rsp_rdata,
    output logic [3:0]  outstanding,
    output logic        proto_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Handshake: an op moves when op_valid & op_ready; the SRAM request moves when
    // data_sram_req & data_sram_addr_ok; responses are returned in order on data_ok.
    logic             hold;
    logic             hold_disc;
    logic [DEPTH-1:0] fifo_wr;
    logic [DEPTH-1:0] fifo_disc;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [3:0]       count;

    logic       accept;
    logic       addr_hs;
    logic       fifo_empty;
    logic       bypass;
    logic       pop;
    logic       push;
    logic       stray;
    logic       rsp_fire;
    logic       ent_wr;
    logic       ent_disc;
    logic       rsp_keep;
    logic [4:0] occupancy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign occupancy  = {1'b0, count} + {4'b0, hold};
    assign op_ready   = ~reset & ~hold & ~flush & (occupancy < 5'(DEPTH));
    assign accept     = op_valid & op_ready;
    assign addr_hs    = hold & data_sram_addr_ok;
    assign fifo_empty = (count == 4'd0);

    // With nothing outstanding, a data_ok that lands on an addr handshake answers that request.
    assign bypass   = data_sram_data_ok & fifo_empty & addr_hs;
    assign pop      = data_sram_data_ok & ~fifo_empty;
    assign push     = addr_hs & ~bypass;
    assign stray    = data_sram_data_ok & fifo_empty & ~addr_hs;
    assign rsp_fire = pop | bypass;
    assign ent_wr   = bypass ? data_sram_wr : fifo_wr[rd_ptr];
    assign ent_disc = (bypass ? hold_disc : fifo_disc[rd_ptr]) | flush;
    assign rsp_keep = rsp_fire & ~ent_disc;

    assign data_sram_req = hold;
    assign outstanding   = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold            <= 1'b0;
            hold_disc       <= 1'b0;
            data_sram_wr    <= 1'b0;
            data_sram_size  <= 2'd0;
            data_sram_addr  <= 32'd0;
            data_sram_wstrb <= 4'd0;
            data_sram_wdata <= 32'd0;
            fifo_wr         <= '0;
            fifo_disc       <= '0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= 4'd0;
            proto_err       <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_wr          <= 1'b0;
            rsp_rdata       <= 32'd0;
        end else begin
            if (accept) begin
                hold            <= 1'b1;
                hold_disc       <= 1'b0;
                data_sram_wr    <= op_wr;
                data_sram_size  <= op_size;
                data_sram_addr  <= op_addr;
                data_sram_wstrb <= op_wstrb;
                data_sram_wdata <= op_wdata;
            end else if (addr_hs) begin
                hold <= 1'b0;
            end else if (hold & flush) begin
                hold_disc <= 1'b1;
            end

            // Flush marks every slot; stale slots are overwritten on their next push anyway.
            if (flush) fifo_disc <= '1;
            if (push) begin
                fifo_wr[wr_ptr]   <= data_sram_wr;
                fifo_disc[wr_ptr] <= hold_disc | flush;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);

            count     <= count + 4'(push) - 4'(pop);
            proto_err <= proto_err | stray;

            rsp_valid <= rsp_keep;
            if (rsp_keep) begin
                rsp_wr    <= ent_wr;
                rsp_rdata <= ent_wr ? 32'd0 : data_sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_data_req_ctrl.sv
// Bench for data_req_ctrl: directed scenarios plus randomized traffic checked against
// a queue-based model of outstanding requests.
module tb_data_req_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        op_valid, op_wr;
    logic [1:0]  op_size;
    logic [31:0] op_addr;
    logic [3:0]  op_wstrb;
    logic [31:0] op_wdata;
    logic        op_ready;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        rsp_valid, rsp_wr;
    logic [31:0] rsp_rdata;
    logic [3:0]  outstanding;
    logic        proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_req_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .op_valid(op_valid), .op_wr(op_wr), .op_size(op_size), .op_addr(op_addr),
        .op_wstrb(op_wstrb), .op_wdata(op_wdata), .op_ready(op_ready),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .rsp_valid(rsp_valid), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata),
        .outstanding(outstanding), .proto_err(proto_err)
    );

    // Reference model: pending responses in issue order, plus the not-yet-issued request.
    typedef struct packed {logic wr; logic disc;} ent_t;
    ent_t        pend_q[$];
    bit          m_hold, m_hdisc, m_hwr, m_proto;
    logic [1:0]  m_hsize;
    logic [31:0] m_haddr, m_hwdata;
    logic [3:0]  m_hwstrb;
    bit          e_rv, e_rwr;
    logic [31:0] e_rdata;

    function automatic bit model_ready();
        return !reset && !flush && !m_hold && (pend_q.size() < DEPTH);
    endfunction

    task automatic idle();
        reset = 0; flush = 0; op_valid = 0; op_wr = 0; op_size = 0; op_addr = 0;
        op_wstrb = 0; op_wdata = 0; data_sram_addr_ok = 0; data_sram_data_ok = 0;
        data_sram_rdata = 0;
    endtask

    // Advance one clock, evolving the model from the inputs presented this cycle.
    task automatic step_clk();
        bit   rdy, hs, fire, byp;
        ent_t e, n;
        rdy = model_ready();
        e = '0;
        if (reset) begin
            pend_q.delete();
            m_hold = 0; m_hdisc = 0; m_proto = 0; e_rv = 0; e_rwr = 0; e_rdata = 0;
        end else begin
            hs = m_hold && data_sram_addr_ok;
            fire = 0; byp = 0;
            if (data_sram_data_ok) begin
                if (pend_q.size() > 0) begin e = pend_q.pop_front(); fire = 1; end
                else if (hs) begin e.wr = m_hwr; e.disc = m_hdisc; byp = 1; fire = 1; end
                else m_proto = 1;
            end
            if (fire) e.disc = e.disc | flush;
            e_rv = fire && !e.disc;
            if (e_rv) begin e_rwr = e.wr; e_rdata = e.wr ? 32'd0 : data_sram_rdata; end
            if (flush) foreach (pend_q[i]) pend_q[i].disc = 1'b1;
            if (hs && !byp) begin n.wr = m_hwr; n.disc = m_hdisc | flush; pend_q.push_back(n); end
            if (hs) m_hold = 0;
            else if (m_hold && flush) m_hdisc = 1;
            if (op_valid && rdy) begin
                m_hold = 1; m_hdisc = 0; m_hwr = op_wr; m_hsize = op_size;
                m_haddr = op_addr; m_hwstrb = op_wstrb; m_hwdata = op_wdata;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle(); reset = 1; step_clk(); reset = 0;
    endtask

    task automatic test_reset();
        idle(); reset = 1; #1;
        n_checks++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL reset_op_ready: got %0b exp 0", op_ready); end
        step_clk();
        n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d exp 0", outstanding); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %0b exp 0", rsp_valid); end
        n_checks++; if (data_sram_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b exp 0", data_sram_req); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto: got %0b exp 0", proto_err); end
        n_checks++; if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h exp 0", rsp_rdata); end
        reset = 0; #1;
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_first_ready: got %0b exp 1", op_ready); end
    endtask

    task automatic test_load();
        do_reset();
        op_valid = 1; op_addr = 32'h1000_0004; op_size = 2'd2; #1;
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready: got %0b exp 1", op_ready); end
        step_clk();
        op_valid = 0; data_sram_addr_ok = 1; #1;
        n_checks++; if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h1000_0004 || data_sram_wr !== 1'b0)
            begin n_fail++; $display("FAIL load_req: got req=%0b addr=%h wr=%0b exp 1 10000004 0", data_sram_req, data_sram_addr, data_sram_wr); end
        step_clk();
        n_checks++; if (outstanding !== 4'd1) begin n_fail++; $display("FAIL load_out1: got %0d exp 1", outstanding); end
        data_sram_addr_ok = 0; step_clk();
        data_sram_data_ok = 1; data_sram_rdata = 32'hDEAD_BEEF; step_clk();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_wr !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF)
            begin n_fail++; $display("FAIL load_rsp: got v=%0b wr=%0b d=%h exp 1 0 deadbeef", rsp_valid, rsp_wr, rsp_rdata); end
        n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("FAIL load_out0: got %0d exp 0", outstanding); end
        data_sram_data_ok = 0; step_clk();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL load_rsp_once: got %0b exp 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        bit exp_rdy[6] = '{1, 0, 1, 0, 0, 0};
        do_reset();
        data_sram_addr_ok = 1; op_valid = 1;
        for (int i = 0; i < 6; i++) begin
            op_addr = 32'h100 + 32'(i * 4); #1;
            n_checks++; if (op_ready !== exp_rdy[i]) begin n_fail++; $display("FAIL b2b_ready_%0d: got %0b exp %0b", i, op_ready, exp_rdy[i]); end
            step_clk();
        end
        n_checks++; if (outstanding !== 4'd2) begin n_fail++; $display("FAIL b2b_full: got %0d exp 2", outstanding); end
        data_sram_data_ok = 1; data_sram_rdata = 32'h11; step_clk();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11) begin n_fail++; $display("FAIL b2b_rsp1: got v=%0b d=%h exp 1 11", rsp_valid, rsp_rdata); end
        data_sram_data_ok = 0; #1;
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_third_ready: got %0b exp 1", op_ready); end
        step_clk(); op_valid = 0; step_clk();
        n_checks++; if (outstanding !== 4'd2) begin n_fail++; $display("FAIL b2b_third_out: got %0d exp 2", outstanding); end
        data_sram_addr_ok = 0; data_sram_data_ok = 1;
        for (int i = 0; i < 2; i++) begin
            data_sram_rdata = 32'h22 + 32'(i); step_clk();
            n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h22 + 32'(i)) begin n_fail++; $display("FAIL b2b_rsp_%0d: got v=%0b d=%h", i, rsp_valid, rsp_rdata); end
        end
        data_sram_data_ok = 0; step_clk();
    endtask

    task automatic test_flush_pending();
        do_reset();
        flush = 1; op_valid = 1; op_addr = 32'h2000_0008; #1;
        n_checks++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_op: got %0b exp 0", op_ready); end
        step_clk();
        n_checks++; if (data_sram_req !== 1'b0) begin n_fail++; $display("FAIL flush_no_accept: got %0b exp 0", data_sram_req); end
        flush = 0; step_clk(); op_valid = 0;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1); #1;
            n_checks++; if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h2000_0008)
                begin n_fail++; $display("FAIL flush_hold_%0d: got req=%0b addr=%h exp 1 20000008", i, data_sram_req, data_sram_addr); end
            step_clk();
        end
        flush = 0; data_sram_addr_ok = 1; step_clk();
        data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h5555; step_clk();
        n_checks++; if (rsp_valid !== 1'b0 || outstanding !== 4'd0) begin n_fail++; $display("FAIL flush_drop: got v=%0b out=%0d exp 0 0", rsp_valid, outstanding); end
        data_sram_data_ok = 0; step_clk();
    endtask

    task automatic test_flush_outstanding();
        do_reset();
        data_sram_addr_ok = 1; op_valid = 1;
        for (int i = 0; i < 4; i++) begin if (i == 3) op_valid = 0; step_clk(); end
        data_sram_addr_ok = 0; flush = 1; step_clk(); flush = 0;
        data_sram_data_ok = 1;
        for (int i = 0; i < 2; i++) begin
            data_sram_rdata = 32'h77; step_clk();
            n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flushq_drop_%0d: got %0b exp 0", i, rsp_valid); end
        end
        data_sram_data_ok = 0; op_valid = 1; op_addr = 32'h3000_0000; step_clk();
        op_valid = 0; data_sram_addr_ok = 1; step_clk();
        data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'hCAFE_F00D; step_clk();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL flushq_new: got v=%0b d=%h exp 1 cafef00d", rsp_valid, rsp_rdata); end
        data_sram_data_ok = 0; step_clk();
    endtask

    task automatic test_bypass();
        do_reset();
        op_valid = 1; op_addr = 32'h44; step_clk();
        op_valid = 0; data_sram_addr_ok = 1; data_sram_data_ok = 1; data_sram_rdata = 32'h1234_5678; step_clk();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || outstanding !== 4'd0 || proto_err !== 1'b0)
            begin n_fail++; $display("FAIL bypass: got v=%0b d=%h out=%0d pe=%0b exp 1 12345678 0 0", rsp_valid, rsp_rdata, outstanding, proto_err); end
        idle(); step_clk();
    endtask

    task automatic test_proto_err();
        do_reset();
        data_sram_data_ok = 1; step_clk();
        n_checks++; if (proto_err !== 1'b1 || outstanding !== 4'd0 || rsp_valid !== 1'b0)
            begin n_fail++; $display("FAIL proto_set: got pe=%0b out=%0d v=%0b exp 1 0 0", proto_err, outstanding, rsp_valid); end
        data_sram_data_ok = 0; step_clk(); step_clk();
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_sticky: got %0b exp 1", proto_err); end
        do_reset();
        n_checks++; if (proto_err !== 1'b0 || outstanding !== 4'd0) begin n_fail++; $display("FAIL proto_clear: got pe=%0b out=%0d exp 0 0", proto_err, outstanding); end
    endtask

    task automatic test_store();
        do_reset();
        op_valid = 1; op_wr = 1; op_size = 2'd1; op_wstrb = 4'b1100; op_wdata = 32'hA5A5_0000; op_addr = 32'h4000_0010;
        step_clk();
        op_valid = 0; #1;
        n_checks++; if (data_sram_wr !== 1'b1 || data_sram_wstrb !== 4'b1100 || data_sram_size !== 2'd1 || data_sram_wdata !== 32'hA5A5_0000)
            begin n_fail++; $display("FAIL store_payload: got wr=%0b st=%b sz=%0d wd=%h", data_sram_wr, data_sram_wstrb, data_sram_size, data_sram_wdata); end
        data_sram_addr_ok = 1; step_clk();
        data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'hFFFF_FFFF; step_clk();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_wr !== 1'b1 || rsp_rdata !== 32'd0)
            begin n_fail++; $display("FAIL store_rsp: got v=%0b wr=%0b d=%h exp 1 1 0", rsp_valid, rsp_wr, rsp_rdata); end
        idle(); step_clk();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            flush = ($urandom_range(0, 15) == 0);
            op_valid = $urandom_range(0, 1); op_wr = $urandom_range(0, 1);
            op_size = 2'($urandom_range(0, 2)); op_addr = $urandom; op_wstrb = 4'($urandom); op_wdata = $urandom;
            data_sram_addr_ok = ($urandom_range(0, 9) < 6);
            data_sram_data_ok = (pend_q.size() > 0 || (m_hold && data_sram_addr_ok)) && ($urandom_range(0, 1) == 1);
            data_sram_rdata = $urandom;
            #1;
            n_checks++; if (op_ready !== model_ready()) begin n_fail++; $display("FAIL rnd_ready c%0d: got %0b exp %0b", c, op_ready, model_ready()); end
            n_checks++; if (data_sram_req !== m_hold) begin n_fail++; $display("FAIL rnd_req c%0d: got %0b exp %0b", c, data_sram_req, m_hold); end
            if (m_hold) begin
                n_checks++; if ({data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata} !== {m_hwr, m_hsize, m_haddr, m_hwstrb, m_hwdata})
                    begin n_fail++; $display("FAIL rnd_payload c%0d: got addr=%h exp %h", c, data_sram_addr, m_haddr); end
            end
            step_clk();
            n_checks++; if (rsp_valid !== e_rv) begin n_fail++; $display("FAIL rnd_rsp_valid c%0d: got %0b exp %0b", c, rsp_valid, e_rv); end
            if (e_rv) begin
                n_checks++; if (rsp_wr !== e_rwr || rsp_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_rsp_data c%0d: got wr=%0b d=%h exp %0b %h", c, rsp_wr, rsp_rdata, e_rwr, e_rdata); end
            end
            n_checks++; if (outstanding !== 4'(pend_q.size())) begin n_fail++; $display("FAIL rnd_out c%0d: got %0d exp %0d", c, outstanding, pend_q.size()); end
            n_checks++; if (proto_err !== m_proto) begin n_fail++; $display("FAIL rnd_proto c%0d: got %0b exp %0b", c, proto_err, m_proto); end
        end
        idle(); step_clk();
    endtask

    initial begin
        idle();
        test_reset();
        test_load();
        test_back_to_back();
        test_flush_pending();
        test_flush_outstanding();
        test_bypass();
        test_proto_err();
        test_store();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
